cache_tag_array: RTL and testbench
==================================

Name: cache_tag_array

Overview:
- Parametrised N-way set-associative tag store with hit compare. Serves I-cache and D-cache refill/lookup controllers.
- Generalises the single-way tag RAM:
  - configurable ways, sets, tag and offset widths;
  - hardware power-on invalidate sweep;
  - per-set round-robin victim selection;
  - explicit set-invalidate port.
- Sits between the cache controller FSM and the data RAMs; all lookup results are registered.

Parameters:
WAYS, 2, number of ways (1..8)
SETS, 128, sets per way (power of two)
TAG_W, 20, tag width (ADDR_W - INDEX_W - OFFSET_W)
OFFSET_W, 5, log2 line bytes
ADDR_W, 32, address width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  lookup request
req_addr  in  ADDR_W  lookup address; index = addr[OFFSET_W+INDEX_W-1:OFFSET_W], tag = upper TAG_W bits
req_ready  out  1  high when lookup accepted (IDLE state)
resp_valid  out  1  lookup result valid
resp_hit  out  1  any way matched and valid
resp_hit_way  out  WAYS  one-hot matching way
resp_victim_way  out  WAYS  one-hot way to refill on miss
resp_victim_valid  out  1  victim line currently valid (dirty-check/writeback needed)
resp_victim_tag  out  TAG_W  victim's stored tag
wr_en  in  1  refill tag write
wr_index  in  INDEX_W  set to write
wr_way  in  WAYS  one-hot way to write
wr_tag  in  TAG_W  tag written; entry valid set to 1
inv_en  in  1  invalidate all ways of inv_index
inv_index  in  INDEX_W  set to invalidate
init_done  out  1  power-on sweep complete

Behaviour:
- States: INIT and IDLE.
- Reset (async, resetn=0):
  - state <= INIT; sweep counter <= 0.
  - All round-robin pointers <= 0.
  - Outputs: req_ready=0, resp_valid=0, resp_hit=0, resp_hit_way=0, resp_victim_way=0, resp_victim_valid=0, resp_victim_tag=0, init_done=0.
  - Reset asserted mid-sweep or mid-lookup aborts it; the sweep restarts from set 0 after release.
- INIT:
  - Each cycle clears valid+tag of all ways at set = counter, then increments the counter.
  - After set SETS-1 is cleared, next cycle: state=IDLE, init_done=1, req_ready=1.
  - Sweep takes exactly SETS cycles after reset release.
  - wr_en, inv_en and req_valid are ignored in INIT.
- IDLE lookup:
  - req_valid accepted in cycle N; resp_valid=1 in cycle N+1 only (single-cycle pulse, no backpressure).
  - A new lookup can be accepted every cycle.
  - resp_hit_way[w] = valid[w] && tag[w]==req tag. If more than one bit is set, this is a software error; resp_hit is still 1.
- Victim selection (same cycle as hit compare): lowest-index invalid way; else the set's round-robin pointer.
  - resp_victim_tag/valid are taken from the selected way.
- Round-robin pointer: per set, INDEX_W-wide table of log2(WAYS) bits. Advances modulo WAYS on every wr_en to that set. Wraps WAYS-1 -> 0.
  - WAYS=1: pointer absent; victim is always way 0.
- Writes: wr_en updates the entry at the clock edge.
  - Lookup in the same cycle to the same set sees the new value (write-first bypass).
  - Simultaneous inv_en and wr_en to the same set: invalidate wins and the write is dropped.
  - Different sets: both performed.
- inv_en clears valid of every way in inv_index; tags are left unchanged. Same-cycle lookup to that set sees the set invalid.

Optional Feature:
- CACHE_TAG_PARITY_EN defined:
  - Each entry stores an extra even-parity bit over {valid, tag}.
  - A way whose parity mismatches on lookup is forced to miss and treated as invalid for victim choice.
  - Output resp_perr (1 bit, reset 0) pulses with resp_valid.
- Undefined: no parity storage and no resp_perr port.

Decomposition:
- Shared package cache_pkg holds:
  - the INDEX_W derivation ($clog2(SETS));
  - the tag-entry typedef {valid, [parity], tag};
  - the FSM state enum {INIT, IDLE}.
- Natural sub-module: cache_tag_way, one way's storage plus compare and write-first bypass, instantiated WAYS times.
- Top level holds the FSM, sweep counter, round-robin table and victim mux.

Test Plan:
- Reset release, SETS=128 -> init_done rises exactly 128 cycles later; req_ready=0 throughout; every lookup afterwards misses.
- Write way0 set 5 tag 0x12345, then lookup addr 0x123450A0 -> next cycle resp_hit=1, resp_hit_way=01.
- Fill both ways of set 3 (tags A, B), then lookup a miss -> victim_way=01, victim_valid=1, victim_tag=A. Refill writes way0, then way1, then way0 again (pointer wraps).
- Same cycle: wr_en set 7 plus lookup set 7 with the same tag -> hit (bypass). Same cycle: inv_en and wr_en set 7 -> set 7 fully invalid afterwards.
- Assert resetn low mid-sweep at set 60 -> all outputs 0 immediately; sweep restarts from 0; init_done after 128 cycles.
- With CACHE_TAG_PARITY_EN, force a parity flip on a valid hitting entry -> resp_hit=0, resp_perr=1, and that way is chosen as victim.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the set-associative tag store: FSM states, per-entry flag bits and index sizing.
// CACHE_TAG_PARITY_EN adds a stored even-parity bit to every entry.
package cache_pkg;

    typedef enum logic {INIT, IDLE} state_t;

    // Flag part of a tag entry; the tag itself is width-parametrised in cache_tag_way.
    typedef struct packed {
        logic valid;
`ifdef CACHE_TAG_PARITY_EN
        logic parity;
`endif
    } entry_flags_t;

    function automatic int index_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

endpackage

// File: rtl/cache_tag_way.sv
// One way of the tag store: valid/tag storage, write-first read bypass and tag compare.
// CACHE_TAG_PARITY_EN adds per-entry parity and a perr output.
module cache_tag_way
    import cache_pkg::*;
#(
    parameter int SETS    = 128,
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 7
) (
    input  logic               clk,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_index,
    input  logic               inv_en,
    input  logic [INDEX_W-1:0] inv_index,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               hit,
    output logic               line_valid,
    output logic [TAG_W-1:0]   line_tag
`ifdef CACHE_TAG_PARITY_EN
    ,
    output logic               perr
`endif
);

    entry_flags_t     flags_mem [SETS];
    logic [TAG_W-1:0] tag_mem   [SETS];
    entry_flags_t     rd_flags;
    logic [TAG_W-1:0] rd_stored;
    logic             par_bad;

    // Later statements win on the same index: sweep clear beats invalidate beats write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            flags_mem[wr_index].valid  <= 1'b1;
`ifdef CACHE_TAG_PARITY_EN
            flags_mem[wr_index].parity <= ^{1'b1, wr_tag};
`endif
            tag_mem[wr_index]          <= wr_tag;
        end
        if (inv_en) begin
            flags_mem[inv_index].valid  <= 1'b0;
`ifdef CACHE_TAG_PARITY_EN
            flags_mem[inv_index].parity <= ^{1'b0, tag_mem[inv_index]};
`endif
        end
        if (clr_en) begin
            flags_mem[clr_index].valid  <= 1'b0;
`ifdef CACHE_TAG_PARITY_EN
            flags_mem[clr_index].parity <= 1'b0;
`endif
            tag_mem[clr_index]          <= '0;
        end
    end

    always_comb begin
        rd_flags  = flags_mem[rd_index];
        rd_stored = tag_mem[rd_index];
        if (wr_en && wr_index == rd_index) begin
            rd_flags.valid  = 1'b1;
`ifdef CACHE_TAG_PARITY_EN
            rd_flags.parity = ^{1'b1, wr_tag};
`endif
            rd_stored       = wr_tag;
        end
        if (inv_en && inv_index == rd_index) begin
            rd_flags.valid  = 1'b0;
`ifdef CACHE_TAG_PARITY_EN
            rd_flags.parity = ^{1'b0, rd_stored};
`endif
        end
    end

`ifdef CACHE_TAG_PARITY_EN
    assign par_bad = rd_flags.parity != ^{rd_flags.valid, rd_stored};
    assign perr    = par_bad;
`else
    assign par_bad = 1'b0;
`endif

    assign line_valid = rd_flags.valid && !par_bad;
    assign line_tag   = rd_stored;
    assign hit        = line_valid && (rd_stored == rd_tag);

endmodule

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store: power-on invalidate sweep, registered hit/victim lookup, round-robin replacement.
// CACHE_TAG_PARITY_EN adds per-entry parity checking and the resp_perr output.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int SETS     = 128,
    parameter int TAG_W    = 20,
    parameter int OFFSET_W = 5,
    parameter int ADDR_W   = 32,
    localparam int INDEX_W = index_w(SETS)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [WAYS-1:0]    resp_hit_way,
    output logic [WAYS-1:0]    resp_victim_way,
    output logic               resp_victim_valid,
    output logic [TAG_W-1:0]   resp_victim_tag,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [WAYS-1:0]    wr_way,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               inv_en,
    input  logic [INDEX_W-1:0] inv_index,
`ifdef CACHE_TAG_PARITY_EN
    output logic               resp_perr,
`endif
    output logic               init_done
);

    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t             state;
    logic [INDEX_W-1:0] sweep_cnt;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               idle, accept, inv_go, wr_go;
    logic [WAYS-1:0]    way_hit, way_valid, victim_oh;
    logic [TAG_W-1:0]   way_tag [WAYS];
    logic [TAG_W-1:0]   victim_tag;
    logic               victim_valid, found;
    logic [PTR_W-1:0]   rr_cur;
    logic               unused_offset;
`ifdef CACHE_TAG_PARITY_EN
    logic [WAYS-1:0]    way_perr;
`endif

    assign req_index     = req_addr[OFFSET_W +: INDEX_W];
    assign req_tag       = req_addr[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    assign idle   = (state == IDLE);
    assign accept = idle && req_valid;
    assign inv_go = idle && inv_en;
    // A refill racing an invalidate of the same set is dropped.
    assign wr_go  = idle && wr_en && !(inv_en && inv_index == wr_index);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_tag_way #(.SETS(SETS), .TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_way (
            .clk        (clk),
            .clr_en     (state == INIT),
            .clr_index  (sweep_cnt),
            .inv_en     (inv_go),
            .inv_index  (inv_index),
            .wr_en      (wr_go && wr_way[w]),
            .wr_index   (wr_index),
            .wr_tag     (wr_tag),
            .rd_index   (req_index),
            .rd_tag     (req_tag),
            .hit        (way_hit[w]),
            .line_valid (way_valid[w]),
            .line_tag   (way_tag[w])
`ifdef CACHE_TAG_PARITY_EN
            ,
            .perr       (way_perr[w])
`endif
        );
    end

    if (WAYS > 1) begin : g_rr
        logic [PTR_W-1:0] rr_ptr [SETS];
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
            end else if (wr_go) begin
                rr_ptr[wr_index] <= (rr_ptr[wr_index] == PTR_W'(WAYS-1)) ? '0 : rr_ptr[wr_index] + 1'b1;
            end
        end
        assign rr_cur = rr_ptr[req_index];
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    always_comb begin
        victim_oh  = '0;
        found      = 1'b0;
        victim_tag = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!way_valid[w] && !found) begin
                victim_oh[w] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!found) victim_oh[rr_cur] = 1'b1;
        victim_valid = |(victim_oh & way_valid);
        for (int w = 0; w < WAYS; w++) victim_tag = victim_tag | (way_tag[w] & {TAG_W{victim_oh[w]}});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= INIT;
            sweep_cnt         <= '0;
            req_ready         <= 1'b0;
            init_done         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_hit_way      <= '0;
            resp_victim_way   <= '0;
            resp_victim_valid <= 1'b0;
            resp_victim_tag   <= '0;
`ifdef CACHE_TAG_PARITY_EN
            resp_perr         <= 1'b0;
`endif
        end else begin
            resp_valid <= accept;
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == INDEX_W'(SETS-1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        resp_hit          <= |way_hit;
                        resp_hit_way      <= way_hit;
                        resp_victim_way   <= victim_oh;
                        resp_victim_valid <= victim_valid;
                        resp_victim_tag   <= victim_tag;
`ifdef CACHE_TAG_PARITY_EN
                        resp_perr         <= |way_perr;
`endif
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_tag_array.sv
// Scoreboard bench for cache_tag_array (2 ways, 128 sets): directed lookups, refills, invalidates and resets.
module tb_cache_tag_array;

    localparam int WAYS = 2, SETS = 128, TAG_W = 20, OFFSET_W = 5, ADDR_W = 32, INDEX_W = 7;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               req_valid = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic               req_ready, resp_valid, resp_hit, resp_victim_valid, init_done;
    logic [WAYS-1:0]    resp_hit_way, resp_victim_way;
    logic [TAG_W-1:0]   resp_victim_tag;
    logic               wr_en = 1'b0;
    logic [INDEX_W-1:0] wr_index = '0;
    logic [WAYS-1:0]    wr_way = '0;
    logic [TAG_W-1:0]   wr_tag = '0;
    logic               inv_en = 1'b0;
    logic [INDEX_W-1:0] inv_index = '0;
`ifdef CACHE_TAG_PARITY_EN
    logic               resp_perr;
`endif

    cache_tag_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_hit_way(resp_hit_way),
        .resp_victim_way(resp_victim_way), .resp_victim_valid(resp_victim_valid),
        .resp_victim_tag(resp_victim_tag), .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
        .wr_tag(wr_tag), .inv_en(inv_en), .inv_index(inv_index),
`ifdef CACHE_TAG_PARITY_EN
        .resp_perr(resp_perr),
`endif
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic [1:0]  hw;
        logic [1:0]  vw;
        logic        vv;
        logic [19:0] vt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [19:0] TA = 20'hAAAAA, TB = 20'hBBBBB, TC = 20'hCCCCC, TD = 20'hDDDDD,
                            TE = 20'hEEEEE, TT = 20'h77777, TU = 20'h88888;

    // Monitor: pops one expectation per response pulse.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (resetn && resp_valid) begin
                n_tests++;
                got = {resp_hit, resp_hit_way, resp_victim_way, resp_victim_valid, resp_victim_tag};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: resp_valid=1 with no lookup pending at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e)
                        begin
                            n_fail++;
                            $display("FAIL resp at %0t: got hit=%b hw=%b vw=%b vv=%b vt=%h, expected hit=%b hw=%b vw=%b vv=%b vt=%h",
                                     $time, got.hit, got.hw, got.vw, got.vv, got.vt, e.hit, e.hw, e.vw, e.vv, e.vt);
                        end
                end
`ifdef CACHE_TAG_PARITY_EN
                n_tests++;
                if (resp_perr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL resp_perr: got %b expected 0", resp_perr);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic lookup(input logic [19:0] tag, input logic [6:0] idx, input exp_t e);
        req_valid = 1'b1;
        req_addr  = {tag, idx, 5'h00};
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic write(input logic [6:0] idx, input logic [1:0] way, input logic [19:0] tag);
        wr_en = 1'b1; wr_index = idx; wr_way = way; wr_tag = tag;
        tick();
        wr_en = 1'b0;
    endtask

    // Counts cycles from reset release until init_done; also flags any early req_ready.
    task automatic wait_init(input string name);
        int cyc;
        logic ready_early;
        cyc = 0;
        ready_early = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (init_done) begin
                cyc = i;
                break;
            end
            if (req_ready) ready_early = 1'b1;
        end
        check({name, "_cycles"}, cyc, 128);
        check({name, "_ready_during_init"}, {31'b0, ready_early}, 0);
        check({name, "_ready_after"}, {31'b0, req_ready}, 1);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_req_ready", {31'b0, req_ready}, 0);
        check("reset_init_done", {31'b0, init_done}, 0);
        check("reset_resp_valid", {31'b0, resp_valid}, 0);

        // Traffic during the sweep must be ignored.
        wr_en = 1'b1; wr_index = 7'd0; wr_way = 2'b01; wr_tag = 20'h55555;
        req_valid = 1'b1; req_addr = {20'h55555, 7'd0, 5'h00};
        inv_en = 1'b0;
        resetn = 1'b1;
        wait_init("init1");
        wr_en = 1'b0; req_valid = 1'b0;

        lookup(20'h55555, 7'd0,   '{1'b0, 2'b00, 2'b01, 1'b0, 20'h0});
        lookup(20'h00000, 7'd100, '{1'b0, 2'b00, 2'b01, 1'b0, 20'h0});

        write(7'd5, 2'b01, 20'h12345);
        req_valid = 1'b1; req_addr = 32'h123450A0;
        exp_q.push_back('{1'b1, 2'b01, 2'b10, 1'b0, 20'h0});
        tick();
        req_valid = 1'b0;
        lookup(20'h12345, 7'd5, '{1'b1, 2'b01, 2'b10, 1'b0, 20'h0});
        lookup(20'h12346, 7'd5, '{1'b0, 2'b00, 2'b10, 1'b0, 20'h0});

        // Round-robin on set 3.
        write(7'd3, 2'b01, TA);
        write(7'd3, 2'b10, TB);
        lookup(TC, 7'd3, '{1'b0, 2'b00, 2'b01, 1'b1, TA});
        write(7'd3, 2'b01, TC);
        lookup(TD, 7'd3, '{1'b0, 2'b00, 2'b10, 1'b1, TB});
        write(7'd3, 2'b10, TD);
        lookup(TD, 7'd3, '{1'b1, 2'b10, 2'b01, 1'b1, TC});
        lookup(TE, 7'd3, '{1'b0, 2'b00, 2'b01, 1'b1, TC});

        // Write-first bypass on set 7.
        wr_en = 1'b1; wr_index = 7'd7; wr_way = 2'b10; wr_tag = TT;
        req_valid = 1'b1; req_addr = {TT, 7'd7, 5'h00};
        exp_q.push_back('{1'b1, 2'b10, 2'b01, 1'b0, 20'h0});
        tick();
        wr_en = 1'b0; req_valid = 1'b0;
        lookup(TT, 7'd7, '{1'b1, 2'b10, 2'b01, 1'b0, 20'h0});

        // Invalidate beats a same-set write.
        inv_en = 1'b1; inv_index = 7'd7;
        wr_en = 1'b1; wr_index = 7'd7; wr_way = 2'b01; wr_tag = TU;
        tick();
        inv_en = 1'b0; wr_en = 1'b0;
        lookup(TT, 7'd7, '{1'b0, 2'b00, 2'b01, 1'b0, 20'h0});
        lookup(TU, 7'd7, '{1'b0, 2'b00, 2'b01, 1'b0, 20'h0});

        // Same-cycle invalidate seen by lookup; stored tag survives.
        inv_en = 1'b1; inv_index = 7'd5;
        req_valid = 1'b1; req_addr = 32'h123450A0;
        exp_q.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 20'h12345});
        tick();
        inv_en = 1'b0; req_valid = 1'b0;

        // Invalidate and write to different sets both take effect.
        inv_en = 1'b1; inv_index = 7'd3;
        wr_en = 1'b1; wr_index = 7'd9; wr_way = 2'b01; wr_tag = 20'h99999;
        tick();
        inv_en = 1'b0; wr_en = 1'b0;
        lookup(20'h99999, 7'd9, '{1'b1, 2'b01, 2'b10, 1'b0, 20'h0});
        lookup(TD, 7'd3, '{1'b0, 2'b00, 2'b01, 1'b0, TC});

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        // Reset while a hit response is being presented.
        req_valid = 1'b1; req_addr = {20'h99999, 7'd9, 5'h00};
        tick();
        req_valid = 1'b0;
        check("pre_reset_hit", {31'b0, resp_hit}, 1);
        resetn = 1'b0;
        #1;
        check("async_rst_resp_valid", {31'b0, resp_valid}, 0);
        check("async_rst_resp_hit", {31'b0, resp_hit}, 0);
        check("async_rst_hit_way", {30'b0, resp_hit_way}, 0);
        check("async_rst_ready", {31'b0, req_ready}, 0);
        check("async_rst_init_done", {31'b0, init_done}, 0);
        repeat (2) tick();

        // Abort the sweep at set 60 and restart it.
        resetn = 1'b1;
        repeat (60) tick();
        check("mid_sweep_init_done", {31'b0, init_done}, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_sweep_rst_ready", {31'b0, req_ready}, 0);
        check("mid_sweep_rst_victim_tag", {12'b0, resp_victim_tag}, 0);
        repeat (2) tick();
        resetn = 1'b1;
        wait_init("init2");

        lookup(20'h99999, 7'd9, '{1'b0, 2'b00, 2'b01, 1'b0, 20'h0});
        lookup(TC, 7'd3, '{1'b0, 2'b00, 2'b01, 1'b0, 20'h0});
        repeat (3) tick();
        check("queue_drained_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
